// File: rtl/sar_bit_bank.sv
// SAR ADC result bank: decodes the conversion-FSM phase strobes, drives the trial code to the
// cap DAC and buffers completed 6-bit results in a 2-entry valid/ready FIFO.
module sar_bit_bank (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       SAR_RESET,
    input  logic [4:0] OUTEN,
    input  logic       VCOMP,
    input  logic       RD_READY,
    output logic [5:0] DAC_CODE,
    output logic [5:0] RD_DATA,
    output logic       RD_VALID,
    output logic       OVERFLOW,
    output logic       PROTO_ERR
);

    localparam int unsigned W  = 6;
    localparam int unsigned CW = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_B5     = 3'd2;
    localparam logic [2:0] S_B4     = 3'd3;
    localparam logic [2:0] S_B3     = 3'd4;
    localparam logic [2:0] S_B2     = 3'd5;
    localparam logic [2:0] S_B1     = 3'd6;
    localparam logic [2:0] S_B0     = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [W-1:0]  dac_d;
    logic          err_d;
    logic          push;
    logic          is_bit;
    logic [2:0]    bit_n;
    logic [2:0]    need;
    logic [2:0]    tgt;

    logic [W-1:0]  tail_q, tail_d;
    logic [W-1:0]  head_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_d;
    logic          ovf_d;
    logic          pop;

    // One-hot bit-phase decode: which bit is resolved, required previous phase, resulting phase
    always_comb begin
        is_bit = 1'b1;
        bit_n  = 3'd0;
        need   = S_IDLE;
        tgt    = S_IDLE;
        case (OUTEN)
            5'b10000: begin bit_n = 3'd5; need = S_SAMPLE; tgt = S_B5; end
            5'b01000: begin bit_n = 3'd4; need = S_B5;     tgt = S_B4; end
            5'b00100: begin bit_n = 3'd3; need = S_B4;     tgt = S_B3; end
            5'b00010: begin bit_n = 3'd2; need = S_B3;     tgt = S_B2; end
            5'b00001: begin bit_n = 3'd1; need = S_B2;     tgt = S_B1; end
            default:  is_bit = 1'b0;
        endcase
    end

    // Phase tracker and trial-code update
    always_comb begin
        state_d = state_q;
        dac_d   = DAC_CODE;
        err_d   = PROTO_ERR;
        push    = 1'b0;
        if (SAR_RESET) begin
            if (OUTEN == 5'd0) begin
                state_d = S_SAMPLE;
                dac_d   = W'(6'b100000);
            end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end
        end else if (OUTEN == 5'd0) begin
            // A zero phase right after BIT1 is the BIT0 decision; elsewhere it is just idle
            if (state_q == S_B1) begin
                state_d  = S_B0;
                dac_d[0] = VCOMP;
                push     = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else if (is_bit && (state_q == need)) begin
            state_d              = tgt;
            dac_d[bit_n]         = VCOMP;
            dac_d[bit_n - 3'd1]  = 1'b1;
        end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end
    end

    // Result FIFO: head lives in RD_DATA, second entry in tail_q
    always_comb begin
        pop    = RD_VALID && RD_READY;
        head_d = RD_DATA;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = OVERFLOW;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = dac_d;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = dac_d;
                end else if (push) begin
                    tail_d = dac_d;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            default: begin
                if (push && pop) begin
                    head_d = tail_q;
                    tail_d = dac_d;
                end else if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end else if (push) begin
                    ovf_d  = 1'b1;
                end
            end
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            DAC_CODE  <= '0;
            PROTO_ERR <= 1'b0;
            RD_DATA   <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            RD_VALID  <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            state_q   <= state_d;
            DAC_CODE  <= dac_d;
            PROTO_ERR <= err_d;
            RD_DATA   <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            RD_VALID  <= valid_d;
            OVERFLOW  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sar_bit_bank.sv
// Scenario bench for sar_bit_bank: expected results are queued when BIT0 is driven and
// checked by a read monitor as the FIFO hands them out.
module tb_sar_bit_bank;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       SAR_RESET;
    logic [4:0] OUTEN;
    logic       VCOMP;
    logic       RD_READY;
    logic [5:0] DAC_CODE;
    logic [5:0] RD_DATA;
    logic       RD_VALID;
    logic       OVERFLOW;
    logic       PROTO_ERR;

    int         vectors = 0;
    int         miscompares = 0;
    logic [5:0] sb[$];
    logic [5:0] trace [0:6];

    sar_bit_bank dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .SAR_RESET (SAR_RESET),
        .OUTEN     (OUTEN),
        .VCOMP     (VCOMP),
        .RD_READY  (RD_READY),
        .DAC_CODE  (DAC_CODE),
        .RD_DATA   (RD_DATA),
        .RD_VALID  (RD_VALID),
        .OVERFLOW  (OVERFLOW),
        .PROTO_ERR (PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    // Read monitor: a handshake in this cycle consumes the oldest expected result
    always @(negedge CLK) begin
        if (RESET_N && RD_VALID && RD_READY) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL read_unexpected: got %h with nothing expected", RD_DATA);
            end else begin
                logic [5:0] exp_d;
                exp_d = sb.pop_front();
                if (RD_DATA !== exp_d) begin
                    miscompares++;
                    $display("FAIL read_data: got %h expected %h", RD_DATA, exp_d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic sr, input logic [4:0] oe, input logic vc);
        SAR_RESET = sr;
        OUTEN     = oe;
        VCOMP     = vc;
        @(posedge CLK);
        #1;
    endtask

    // Model of the 2-entry FIFO admission for a result about to be pushed
    task automatic expect_push(input logic [5:0] code);
        if (sb.size() < 2 || RD_READY)
            sb.push_back(code);
    endtask

    task automatic run_conv(input logic [5:0] code);
        cyc(1'b1, 5'd0, 1'b0);
        for (int k = 5; k >= 1; k--)
            cyc(1'b0, 5'(1 << (k - 1)), code[k]);
        expect_push(code);
        cyc(1'b0, 5'd0, code[0]);
    endtask

    task automatic test_reset;
        RESET_N = 1'b1; SAR_RESET = 1'b0; OUTEN = 5'd0; VCOMP = 1'b0; RD_READY = 1'b0;
        #2 RESET_N = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        vectors++;
        if ({DAC_CODE, RD_DATA, RD_VALID, OVERFLOW, PROTO_ERR} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected 0",
                     {DAC_CODE, RD_DATA, RD_VALID, OVERFLOW, PROTO_ERR});
        end
        #1 RESET_N = 1'b1;
    endtask

    task automatic test_standard;
        logic [5:0] v;
        v = 6'b101101;
        trace = '{6'b100000, 6'b110000, 6'b101000, 6'b101100, 6'b101110, 6'b101101, 6'b101101};
        RD_READY = 1'b0;
        cyc(1'b1, 5'd0, 1'b0);
        vectors++;
        if (DAC_CODE !== trace[0]) begin
            miscompares++;
            $display("FAIL dac_trace[0]: got %b expected %b", DAC_CODE, trace[0]);
        end
        for (int k = 5; k >= 1; k--) begin
            cyc(1'b0, 5'(1 << (k - 1)), v[k]);
            vectors++;
            if (DAC_CODE !== trace[6 - k]) begin
                miscompares++;
                $display("FAIL dac_trace[%0d]: got %b expected %b", 6 - k, DAC_CODE, trace[6 - k]);
            end
        end
        vectors++;
        if (RD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_early: got %b expected 0", RD_VALID);
        end
        expect_push(v);
        cyc(1'b0, 5'd0, v[0]);
        vectors++;
        if (DAC_CODE !== trace[6]) begin
            miscompares++;
            $display("FAIL dac_trace[6]: got %b expected %b", DAC_CODE, trace[6]);
        end
        vectors++;
        if (RD_VALID !== 1'b1 || RD_DATA !== 6'h2D) begin
            miscompares++;
            $display("FAIL std_result: got valid=%b data=%h expected valid=1 data=2d", RD_VALID, RD_DATA);
        end
        RD_READY = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (RD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL std_drain: got valid=%b expected 0", RD_VALID);
        end
    endtask

    task automatic test_stuck;
        RD_READY = 1'b0;
        run_conv(6'h00);
        run_conv(6'h3F);
        vectors++;
        if (RD_VALID !== 1'b1 || RD_DATA !== 6'h00) begin
            miscompares++;
            $display("FAIL stuck_head: got valid=%b data=%h expected valid=1 data=00", RD_VALID, RD_DATA);
        end
        for (int i = 0; i < 6; i++) begin
            RD_READY = (i % 2 == 1);
            cyc(1'b0, 5'd0, 1'b0);
        end
        RD_READY = 1'b0;
        vectors++;
        if (RD_VALID !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stuck_drain: got valid=%b pending=%0d expected valid=0 pending=0",
                     RD_VALID, sb.size());
        end
    endtask

    task automatic test_overflow;
        RD_READY = 1'b0;
        run_conv(6'h01);
        run_conv(6'h02);
        run_conv(6'h03);
        vectors++;
        if (RD_VALID !== 1'b1 || RD_DATA !== 6'h01 || OVERFLOW !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_state: got valid=%b data=%h ovf=%b expected 1/01/1",
                     RD_VALID, RD_DATA, OVERFLOW);
        end
        RD_READY = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (RD_VALID !== 1'b1 || RD_DATA !== 6'h02) begin
            miscompares++;
            $display("FAIL ovf_second: got valid=%b data=%h expected 1/02", RD_VALID, RD_DATA);
        end
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (RD_VALID !== 1'b0 || OVERFLOW !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_drain: got valid=%b ovf=%b expected 0/1", RD_VALID, OVERFLOW);
        end
    endtask

    task automatic test_restart;
        RD_READY = 1'b1;
        cyc(1'b1, 5'd0, 1'b0);
        cyc(1'b0, 5'b10000, 1'b1);
        cyc(1'b0, 5'b01000, 1'b0);
        cyc(1'b1, 5'd0, 1'b1);
        vectors++;
        if (DAC_CODE !== 6'b100000 || PROTO_ERR !== 1'b0 || RD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL restart: got dac=%b err=%b valid=%b expected 100000/0/0",
                     DAC_CODE, PROTO_ERR, RD_VALID);
        end
        for (int k = 5; k >= 1; k--)
            cyc(1'b0, 5'(1 << (k - 1)), (k % 2 == 0));
        expect_push(6'h15);
        cyc(1'b0, 5'd0, 1'b1);
        vectors++;
        if (RD_VALID !== 1'b1 || RD_DATA !== 6'h15) begin
            miscompares++;
            $display("FAIL restart_result: got valid=%b data=%h expected 1/15", RD_VALID, RD_DATA);
        end
        cyc(1'b0, 5'd0, 1'b0);
    endtask

    task automatic test_illegal;
        RD_READY = 1'b1;
        cyc(1'b1, 5'd0, 1'b0);
        cyc(1'b0, 5'b10000, 1'b1);
        cyc(1'b0, 5'b00110, 1'b1);
        vectors++;
        if (PROTO_ERR !== 1'b1 || DAC_CODE !== 6'b110000) begin
            miscompares++;
            $display("FAIL illegal_onehot: got err=%b dac=%b expected 1/110000", PROTO_ERR, DAC_CODE);
        end
        // Tracker must be idle: the rest of the sequence cannot complete a conversion
        for (int k = 4; k >= 1; k--)
            cyc(1'b0, 5'(1 << (k - 1)), 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (RD_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_nopush: got valid=%b expected 0", RD_VALID);
        end
        cyc(1'b1, 5'd0, 1'b0);
        for (int k = 3; k >= 1; k--)
            cyc(1'b0, 5'(1 << (k - 1)), 1'b1);
        cyc(1'b0, 5'd0, 1'b1);
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (RD_VALID !== 1'b0 || PROTO_ERR !== 1'b1) begin
            miscompares++;
            $display("FAIL skip_b5: got valid=%b err=%b expected 0/1", RD_VALID, PROTO_ERR);
        end
        run_conv(6'h26);
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (PROTO_ERR !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL err_sticky: got err=%b pending=%0d expected 1/0", PROTO_ERR, sb.size());
        end
    endtask

    task automatic test_async_reset;
        RD_READY = 1'b0;
        run_conv(6'h2A);
        cyc(1'b1, 5'd0, 1'b0);
        cyc(1'b0, 5'b10000, 1'b1);
        cyc(1'b0, 5'b01000, 1'b1);
        cyc(1'b0, 5'b00100, 1'b0);
        SAR_RESET = 1'b0; OUTEN = 5'b00010; VCOMP = 1'b1;
        #3 RESET_N = 1'b0;
        #1;
        vectors++;
        if ({DAC_CODE, RD_DATA, RD_VALID, OVERFLOW, PROTO_ERR} !== 15'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected 0",
                     {DAC_CODE, RD_DATA, RD_VALID, OVERFLOW, PROTO_ERR});
        end
        sb.delete();
        @(posedge CLK);
        #2 RESET_N = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        run_conv(6'h33);
        vectors++;
        if (RD_VALID !== 1'b1 || RD_DATA !== 6'h33) begin
            miscompares++;
            $display("FAIL post_reset: got valid=%b data=%h expected 1/33", RD_VALID, RD_DATA);
        end
        RD_READY = 1'b1;
        cyc(1'b0, 5'd0, 1'b0);
        vectors++;
        if (RD_VALID !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_single: got valid=%b pending=%0d expected 0/0", RD_VALID, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_standard();
        test_stuck();
        test_overflow();
        test_restart();
        test_illegal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sar_bit_bank.md
# sar_bit_bank

Per-bit result register bank and readout buffer for the 6-bit SAR ADC. It is the receiving end of the big conversion FSM's control interface. It consumes the phase strobes (SAR_RESET, one-hot OUTEN) together with the comparator decision VCOMP, and from them drives the trial code to the capacitive DAC and assembles the final 6-bit result, including the LSB. Completed conversions are buffered in a 2-entry FIFO with a valid/ready read port toward the digital back end.

## Interface
- No parameters; width fixed at 6 bits, FIFO depth fixed at 2.
- CLK  in  1  conversion clock, same clock as the conversion FSM; all logic rising-edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SAR_RESET  in  1  sample-phase strobe from the conversion FSM.
- OUTEN  in  5  one-hot bit-phase enables; [4] selects BIT5 … [0] selects BIT1.
- VCOMP  in  1  comparator decision. 1 = input above DAC, so the trial bit is kept. Sampled at CLK rising edge, no synchronizer in this block.
- RD_READY  in  1  back end accepts RD_DATA this cycle.
- DAC_CODE  out  6  registered trial/result code driving the cap DAC.
- RD_DATA  out  6  head-of-FIFO conversion result.
- RD_VALID  out  1  FIFO non-empty.
- OVERFLOW  out  1  sticky: a completed result was dropped.
- PROTO_ERR  out  1  sticky: illegal or out-of-order strobe pattern seen.

## Operation
- Phase decode each cycle from the inputs:
  - P_SAMPLE = SAR_RESET=1, OUTEN=0.
  - P_Bk = SAR_RESET=0 with OUTEN one-hot; bit [k-1] gives P_B5..P_B1.
  - P_ZERO = SAR_RESET=0, OUTEN=0.
  - Anything else is illegal.
- Tracker state register, states IDLE, SAMPLE, B5, B4, B3, B2, B1, B0. It records the phase of the previous cycle.
- Transitions, evaluated at each edge:
  - P_SAMPLE from any state goes to SAMPLE.
  - P_B5 is legal only from SAMPLE, and goes to B5.
  - P_B4 from B5, P_B3 from B4, P_B2 from B3, P_B1 from B2.
  - P_ZERO from B1 is the BIT0 phase and goes to B0.
  - P_ZERO from any other state goes to IDLE, with no error.
  - An out-of-order P_Bk, or any illegal pattern, goes to IDLE and sets PROTO_ERR. Any conversion in flight is aborted with no push.
- DAC_CODE update at the edge:
  - P_SAMPLE loads 6'b100000. A SAR_RESET arriving mid-conversion restarts cleanly.
  - A legal P_Bn writes VCOMP into bit n and sets bit n-1 to 1 (the next trial). Bits above n are held.
  - BIT0 writes VCOMP into bit 0, and the completed code is pushed to the FIFO.
  - In all other cases DAC_CODE holds.
- Pushed value is {DAC_CODE[5:1], VCOMP}, identical to the DAC_CODE value after the BIT0 edge.
- FIFO: 2 entries, first in first out.
  - Pop when RD_VALID and RD_READY are both high.
  - Push and pop in the same cycle are both honoured, even when the FIFO is full.
  - Push while full with no pop: the new result is dropped, the stored data is unchanged, and OVERFLOW is set.
- OVERFLOW and PROTO_ERR clear only on RESET_N.

## Timing
- Reset values: DAC_CODE=0, RD_DATA=0, RD_VALID=0, OVERFLOW=0, PROTO_ERR=0, tracker=IDLE, FIFO empty.
- Reset is asynchronous and may assert mid-conversion. It aborts the conversion and discards FIFO contents.
- DAC_CODE changes one edge after its phase cycle:
  - P_SAMPLE gives 100000 in the BIT5 cycle.
  - Each trial code is stable for the whole following phase cycle.
- Conversion period is 7 cycles: SAMPLE, then BIT5..BIT1, then BIT0.
- RD_VALID rises in the cycle after the BIT0 cycle, with RD_DATA valid in that same cycle.
- RD_DATA and RD_VALID are registered. RD_DATA holds while RD_VALID=1 and RD_READY=0.
- Empty FIFO: RD_READY is ignored and RD_DATA holds its last value.

## Test plan
- Reset, then a standard sequence with VCOMP = 1,0,1,1,0,1 over BIT5..BIT0:
  - DAC_CODE trace: 100000, 110000, 101000, 101100, 101110, 101101, 101101.
  - RD_VALID=1 with RD_DATA=6'h2D one cycle after BIT0.
- VCOMP stuck at 0: result 6'h00. VCOMP stuck at 1: result 6'h3F. Read both back in order with RD_READY=1 on alternate cycles.
- RD_READY held at 0 across three conversions with results 0x01, 0x02, 0x03:
  - FIFO holds 0x01 then 0x02, and OVERFLOW=1.
  - After RD_READY=1 the reads are 0x01, then 0x02, then RD_VALID=0.
- SAR_RESET reasserted during BIT3:
  - DAC_CODE returns to 100000 the next cycle, nothing is pushed, and PROTO_ERR stays 0.
  - The following full conversion pushes its correct result.
- Illegal strobes:
  - OUTEN=5'b00110, or BIT3 issued directly after SAMPLE, sets PROTO_ERR=1, returns the tracker to IDLE, and pushes nothing.
  - PROTO_ERR stays 1 until RESET_N.
- RESET_N pulsed low mid-BIT2 with one result already buffered:
  - All outputs return to reset values asynchronously and the buffered result is lost.
  - The next full conversion produces a correct single entry.
